// File: rtl/por_reset_sequencer.sv
// Purpose: turns the async pad-ring power-good level into clean, staggered core/user resets.
// Latency: rst_core releases SYNC_STAGES+FILT_CYCLES+HOLD_CYCLES-1 edges after por_l rises; rst_user STAGGER_CYCLES later.
// Backpressure: none; a control-plane block with level inputs and registered level outputs.
module por_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int FILT_CYCLES    = 16,
    parameter int HOLD_CYCLES    = 1024,
    parameter int STAGGER_CYCLES = 64,
    parameter int CNT_W          = 11
) (
    input  logic clock,
    input  logic reset,
    input  logic por_l,
    input  logic force_rst,
    input  logic clr_flag,
    output logic rst_core,
    output logic rst_user,
    output logic por_ok,
    output logic brownout_flag
);

    // Largest terminal count any phase needs; the shared counters must reach it.
    localparam int MAX_CYCLES =
        (FILT_CYCLES > HOLD_CYCLES)
            ? ((FILT_CYCLES > STAGGER_CYCLES) ? FILT_CYCLES : STAGGER_CYCLES)
            : ((HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES);

    // Refuse to elaborate with a configuration that cannot work.
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("por_reset_sequencer: SYNC_STAGES must be at least 2");
    end
    if (FILT_CYCLES < 1 || HOLD_CYCLES < 1 || STAGGER_CYCLES < 1) begin : g_bad_cycles
        $error("por_reset_sequencer: cycle counts must be at least 1");
    end
    if (MAX_CYCLES > (2 ** CNT_W) - 1) begin : g_bad_cnt_w
        $error("por_reset_sequencer: CNT_W too small for the largest cycle count");
    end

    // Terminal values: a phase ends on the edge where the counter already holds N-1.
    localparam logic [CNT_W-1:0] FILT_LAST = CNT_W'(FILT_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FILTER  = 3'd1,
        ST_HOLD    = 3'd2,
        ST_STAGGER = 3'd3,
        ST_RUN     = 3'd4
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   por_s;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             rst_core_q, rst_core_d;
    logic             rst_user_q, rst_user_d;
    logic             por_ok_q, por_ok_d;
    logic             flag_q, flag_d;

    logic in_watch;
    logic drop_hit;

    // Bring the async power-good level into the clock domain; only the last stage is trusted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], por_l};
        end
    end

    assign por_s = sync_q[SYNC_STAGES-1];

    // Once hold-off has begun, a sustained low on por_s is a brownout.
    assign in_watch = (state_q == ST_HOLD) || (state_q == ST_STAGGER) || (state_q == ST_RUN);
    assign drop_hit = in_watch && !por_s && (dcnt_q >= FILT_LAST);

    // Sequencer state, counters and registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dcnt_q     <= '0;
            rst_core_q <= 1'b1;
            rst_user_q <= 1'b1;
            por_ok_q   <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dcnt_q     <= dcnt_d;
            rst_core_q <= rst_core_d;
            rst_user_q <= rst_user_d;
            por_ok_q   <= por_ok_d;
            flag_q     <= flag_d;
        end
    end

    // Next-state and next-output logic: force_rst beats the drop filter, which beats normal sequencing.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rst_core_d = rst_core_q;
        rst_user_d = rst_user_q;
        por_ok_d   = por_ok_q;
        // A brownout detected in the same cycle as clr_flag must survive, so set is applied after clear.
        flag_d     = flag_q & ~clr_flag;

        // Drop counter only runs while watching for brownout; any high sample restarts it.
        if (in_watch && !por_s) begin
            dcnt_d = dcnt_q + CNT_ONE;
        end else begin
            dcnt_d = '0;
        end

        if (force_rst) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            dcnt_d     = '0;
            rst_core_d = 1'b1;
            rst_user_d = 1'b1;
            por_ok_d   = 1'b0;
        end else if (drop_hit) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            dcnt_d     = '0;
            rst_core_d = 1'b1;
            rst_user_d = 1'b1;
            por_ok_d   = 1'b0;
            flag_d     = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rst_core_d = 1'b1;
                    rst_user_d = 1'b1;
                    por_ok_d   = 1'b0;
                    // The sample that triggers the move already counts toward the filter.
                    if (por_s) begin
                        state_d = ST_FILTER;
                        cnt_d   = CNT_ONE;
                    end
                end
                ST_FILTER: begin
                    if (!por_s) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q >= FILT_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q >= HOLD_LAST) begin
                        state_d    = ST_STAGGER;
                        cnt_d      = '0;
                        rst_core_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_STAGGER: begin
                    rst_core_d = 1'b0;
                    if (cnt_q >= STAG_LAST) begin
                        state_d    = ST_RUN;
                        cnt_d      = '0;
                        rst_user_d = 1'b0;
                        por_ok_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_RUN: begin
                    rst_core_d = 1'b0;
                    rst_user_d = 1'b0;
                    por_ok_d   = 1'b1;
                end
                default: begin
                    state_d    = ST_IDLE;
                    cnt_d      = '0;
                    dcnt_d     = '0;
                    rst_core_d = 1'b1;
                    rst_user_d = 1'b1;
                    por_ok_d   = 1'b0;
                end
            endcase
        end
    end

    assign rst_core      = rst_core_q;
    assign rst_user      = rst_user_q;
    assign por_ok        = por_ok_q;
    assign brownout_flag = flag_q;

endmodule

// File: tb/tb_por_reset_sequencer.sv
// Directed bench for por_reset_sequencer with small cycle counts.
// Expected output tuples {rst_core, rst_user, por_ok, brownout_flag} are queued before each edge and checked after it.
module tb_por_reset_sequencer;

    localparam int SYNC   = 2;
    localparam int FILT   = 4;
    localparam int HOLD   = 8;
    localparam int STAG   = 4;
    // Edge index (edge 0 = first edge after por_l rises) where each reset releases.
    localparam int CORE_E = SYNC + FILT + HOLD - 1;  // 13
    localparam int USER_E = CORE_E + STAG;           // 17
    // Brownout: por_l low before edge 0 -> reset re-asserts after edge SYNC+FILT-1.
    localparam int DROP_E = SYNC + FILT - 1;         // 5

    logic clock = 1'b0;
    logic reset;
    logic por_l;
    logic force_rst;
    logic clr_flag;
    logic rst_core;
    logic rst_user;
    logic por_ok;
    logic brownout_flag;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string      tag;
        logic [3:0] v;
    } exp_t;

    exp_t sb[$];

    por_reset_sequencer #(
        .SYNC_STAGES   (SYNC),
        .FILT_CYCLES   (FILT),
        .HOLD_CYCLES   (HOLD),
        .STAGGER_CYCLES(STAG),
        .CNT_W         (4)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .por_l        (por_l),
        .force_rst    (force_rst),
        .clr_flag     (clr_flag),
        .rst_core     (rst_core),
        .rst_user     (rst_user),
        .por_ok       (por_ok),
        .brownout_flag(brownout_flag)
    );

    always #5 clock = ~clock;

    function automatic logic [3:0] pat(input logic rc, input logic ru, input logic ok, input logic fl);
        return {rc, ru, ok, fl};
    endfunction

    task automatic cmp(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Compare current outputs and the rst_user-never-before-rst_core invariant.
    task automatic check_now(input string tag, input logic [3:0] exp);
        cmp(tag, {rst_core, rst_user, por_ok, brownout_flag}, exp);
        cmp({tag, "/inv"}, {3'b000, (rst_core === 1'b1 && rst_user === 1'b0)}, 4'b0000);
    endtask

    // Queue the expectation for the coming edge, then check it 1 time unit after that edge.
    task automatic step(input string tag, input logic [3:0] exp);
        exp_t e;
        e.tag = tag;
        e.v   = exp;
        sb.push_back(e);
        @(posedge clock);
        #1;
        e = sb.pop_front();
        check_now(e.tag, e.v);
    endtask

    // Release sequence checks for edges first..last of a power-up counted from the por_l rise.
    task automatic seq_check(input string tag, input int first, input int last, input logic fl);
        for (int e = first; e <= last; e++) begin
            step($sformatf("%s@%0d", tag, e),
                 pat(e < CORE_E, e < USER_E, e >= USER_E, fl));
        end
    endtask

    initial begin
        reset     = 1'b1;
        por_l     = 1'b0;
        force_rst = 1'b0;
        clr_flag  = 1'b0;

        // Reset values while reset is held, then just after release.
        step("rst_held0", pat(1, 1, 0, 0));
        step("rst_held1", pat(1, 1, 0, 0));
        reset = 1'b0;
        step("rst_rel0", pat(1, 1, 0, 0));
        step("rst_rel1", pat(1, 1, 0, 0));

        // Power-up: rst_core falls at edge 13, rst_user/por_ok at edge 17.
        por_l = 1'b1;
        seq_check("pwrup", 0, 20, 1'b0);

        // Short drop (3 low samples) in RUN is ignored.
        por_l = 1'b0;
        for (int i = 0; i < 3; i++) step($sformatf("short_lo%0d", i), pat(0, 0, 1, 0));
        por_l = 1'b1;
        for (int i = 0; i < 6; i++) step($sformatf("short_hi%0d", i), pat(0, 0, 1, 0));

        // Sustained drop in RUN: reset re-asserts and brownout_flag sets.
        por_l = 1'b0;
        for (int e = 0; e <= 8; e++) begin
            if (e < DROP_E) step($sformatf("brown@%0d", e), pat(0, 0, 1, 0));
            else            step($sformatf("brown@%0d", e), pat(1, 1, 0, 1));
        end

        // Glitch: 3 cycles high is rejected by the filter; flag persists.
        por_l = 1'b1;
        for (int e = 0; e < 3; e++) step($sformatf("glitch_hi@%0d", e), pat(1, 1, 0, 1));
        por_l = 1'b0;
        for (int e = 3; e < 18; e++) step($sformatf("glitch_lo@%0d", e), pat(1, 1, 0, 1));

        // Full power-up again with the sticky flag still set.
        por_l = 1'b1;
        seq_check("pwrup2", 0, 20, 1'b1);

        // force_rst pulse in RUN; counting the force edge as edge 1, release lands on 13/17 again.
        force_rst = 1'b1;
        step("force_pulse@1", pat(1, 1, 0, 1));
        force_rst = 1'b0;
        seq_check("force_seq", 2, 20, 1'b1);

        // force_rst held as a level keeps everything in reset; sequence restarts on release.
        force_rst = 1'b1;
        for (int i = 0; i < 5; i++) step($sformatf("force_hold%0d", i), pat(1, 1, 0, 1));
        force_rst = 1'b0;
        seq_check("force_rel", 2, 20, 1'b1);

        // clr_flag alone clears the flag on the next edge without disturbing RUN.
        clr_flag = 1'b1;
        step("clr_alone", pat(0, 0, 1, 0));
        clr_flag = 1'b0;
        step("clr_after", pat(0, 0, 1, 0));

        // New brownout with clr_flag on the very edge the drop is accepted: set wins.
        por_l = 1'b0;
        for (int e = 0; e < DROP_E; e++) step($sformatf("coinc@%0d", e), pat(0, 0, 1, 0));
        clr_flag = 1'b1;
        step("coinc_hit", pat(1, 1, 0, 1));
        clr_flag = 1'b0;
        step("coinc_after0", pat(1, 1, 0, 1));
        step("coinc_after1", pat(1, 1, 0, 1));

        // Power up into HOLD (entered at edge 5), then async reset mid-HOLD.
        por_l = 1'b1;
        seq_check("to_hold", 0, 8, 1'b1);
        reset = 1'b1;
        #2;
        check_now("arst_immediate", pat(1, 1, 0, 0));
        step("arst_held0", pat(1, 1, 0, 0));
        step("arst_held1", pat(1, 1, 0, 0));
        reset = 1'b0;
        // por_l already high, synchronizer cleared: a clean power-up from edge 0.
        seq_check("post_arst", 0, 20, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
